// File: rtl/cmplx_accum_if.sv
// Valid/ready stream bundle for the complex accumulator: product beats in,
// rounded/saturated frame sums out.
interface cmplx_accum_if #(
  parameter int QI = 3,
  parameter int QF = 3,
  parameter int N  = 8
);
  localparam int PW = 2*QI + 2*QF + 1;
  localparam int OW = QI + QF;
  localparam int CW = $clog2(N) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic signed [PW-1:0] p_Re;
  logic signed [PW-1:0] p_Im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] y_Re;
  logic signed [OW-1:0] y_Im;
  logic                 y_sat;
  logic [CW-1:0]        out_count;

  modport master (
    output in_valid, in_last, p_Re, p_Im, out_ready,
    input  in_ready, out_valid, y_Re, y_Im, y_sat, out_count
  );

  modport slave (
    input  in_valid, in_last, p_Re, p_Im, out_ready,
    output in_ready, out_valid, y_Re, y_Im, y_sat, out_count
  );
endinterface

// File: rtl/cmplx_accum.sv
// Frame accumulator for full-precision complex products; rounds half-up and
// saturates the guarded sum back to the operand format.
module cmplx_accum #(
  parameter int QI = 3,
  parameter int QF = 3,
  parameter int N  = 8
) (
  input  logic          clk,
  input  logic          rst,
  cmplx_accum_if.slave  bus
);
  localparam int PW = 2*QI + 2*QF + 1;
  localparam int GW = $clog2(N);
  localparam int AW = PW + GW;
  localparam int OW = QI + QF;
  localparam int CW = GW + 1;
  localparam int RW = AW - QF + 1;

  localparam logic signed [AW:0]   HALF  = (AW+1)'(1 << (QF-1));
  localparam logic signed [RW-1:0] R_MAX = RW'((1 << (OW-1)) - 1);
  localparam logic signed [RW-1:0] R_MIN = RW'(-(1 << (OW-1)));

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_ROUND, S_OUT} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic signed [AW-1:0] r_acc_re;
  logic signed [AW-1:0] r_acc_im;
  logic [CW-1:0]        r_cnt;
  logic signed [OW-1:0] r_y_re;
  logic signed [OW-1:0] r_y_im;
  logic                 r_y_sat;
  logic [CW-1:0]        r_out_count;

  logic                 w_accept;
  logic                 w_close;
  logic [CW-1:0]        w_cnt_inc;
  logic signed [AW-1:0] w_p_re_ext;
  logic signed [AW-1:0] w_p_im_ext;
  logic [OW:0]          w_re_rs;
  logic [OW:0]          w_im_rs;

  // Returns {clamped, value}: half-up rounding, then clamp to the output range.
  // One extra headroom bit keeps the rounding offset from wrapping a full sum.
  function automatic logic [OW:0] round_sat(input logic signed [AW-1:0] a);
    logic signed [AW:0]   t;
    logic signed [RW-1:0] r;
    t = {a[AW-1], a} + HALF;
    r = RW'(t >>> QF);
    if (r > R_MAX)      round_sat = {1'b1, R_MAX[OW-1:0]};
    else if (r < R_MIN) round_sat = {1'b1, R_MIN[OW-1:0]};
    else                round_sat = {1'b0, r[OW-1:0]};
  endfunction

  assign bus.in_ready = !rst && (r_state == S_IDLE || r_state == S_ACC);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_cnt_inc    = r_cnt + CW'(1);
  // cnt is zero in IDLE, so the same test also closes a frame when N == 1.
  assign w_close      = bus.in_last || (w_cnt_inc == CW'(N));
  assign w_p_re_ext   = {{GW{bus.p_Re[PW-1]}}, bus.p_Re};
  assign w_p_im_ext   = {{GW{bus.p_Im[PW-1]}}, bus.p_Im};
  assign w_re_rs      = round_sat(r_acc_re);
  assign w_im_rs      = round_sat(r_acc_im);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE,
      S_ACC:   if (w_accept && w_close) w_state_nxt = S_ROUND;
               else if (w_accept)       w_state_nxt = S_ACC;
      S_ROUND: w_state_nxt = S_OUT;
      S_OUT:   if (bus.out_ready)       w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_re    <= '0;
      r_acc_im    <= '0;
      r_cnt       <= '0;
      r_y_re      <= '0;
      r_y_im      <= '0;
      r_y_sat     <= 1'b0;
      r_out_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_acc_re <= w_p_re_ext;
          r_acc_im <= w_p_im_ext;
          r_cnt    <= CW'(1);
        end
        S_ACC: if (w_accept) begin
          r_acc_re <= r_acc_re + w_p_re_ext;
          r_acc_im <= r_acc_im + w_p_im_ext;
          r_cnt    <= w_cnt_inc;
        end
        S_ROUND: begin
          r_y_re      <= w_re_rs[OW-1:0];
          r_y_im      <= w_im_rs[OW-1:0];
          r_y_sat     <= w_re_rs[OW] | w_im_rs[OW];
          r_out_count <= r_cnt;
        end
        S_OUT: if (bus.out_ready) begin
          r_acc_re <= '0;
          r_acc_im <= '0;
          r_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = (r_state == S_OUT);
  assign bus.y_Re      = r_y_re;
  assign bus.y_Im      = r_y_im;
  assign bus.y_sat     = r_y_sat;
  assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_cmplx_accum.sv
// Directed bench for cmplx_accum: latency, gaps, rounding, saturation,
// length limit with stall, backpressure and mid-frame reset.
module tb_cmplx_accum;
  localparam int QI = 3;
  localparam int QF = 3;
  localparam int N  = 8;
  localparam int PW = 2*QI + 2*QF + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  cmplx_accum_if #(.QI(QI), .QF(QF), .N(N)) bus ();

  cmplx_accum #(.QI(QI), .QF(QF), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Offers one beat from a negedge; returns just after the accepting edge.
  task automatic send_beat(input int re, input int im, input bit last);
    int waits = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.p_Re     = PW'(re);
    bus.p_Im     = PW'(im);
    while (!bus.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("beat_accept", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take_result(input string tag, input int re, input int im,
                             input int sat, input int cnt);
    int waits = 0;
    @(negedge clk);
    while (!bus.out_valid && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check({tag, "_valid"}, int'(bus.out_valid), 1);
    check({tag, "_re"},    $signed(bus.y_Re), re);
    check({tag, "_im"},    $signed(bus.y_Im), im);
    check({tag, "_sat"},   int'(bus.y_sat), sat);
    check({tag, "_count"}, int'(bus.out_count), cnt);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.p_Re      = '0;
    bus.p_Im      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_y_re", $signed(bus.y_Re), 0);
    check("rst_count", int'(bus.out_count), 0);

    // 1: single beat 1.5 - 1.0i, two-cycle latency
    send_beat(96, -64, 1'b1);
    @(negedge clk);
    check("t1_round_no_valid", int'(bus.out_valid), 0);
    check("t1_round_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    check("t1_latency_valid", int'(bus.out_valid), 1);
    take_result("t1", 12, -8, 0, 4'd1);

    // 2: four beats with a two-cycle gap after beat 2
    send_beat(16, 8, 1'b0);
    send_beat(16, 8, 1'b0);
    repeat (2) @(negedge clk);
    check("t2_gap_no_valid", int'(bus.out_valid), 0);
    send_beat(16, 8, 1'b0);
    send_beat(16, 8, 1'b1);
    take_result("t2", 8, 4, 0, 4);

    // 3: half-up rounding in both directions
    send_beat(4, -4, 1'b1);
    take_result("t3", 1, 0, 0, 1);

    // 4: saturation on both components
    for (int i = 0; i < 3; i++) send_beat(192, -192, i == 2);
    take_result("t4", 31, -32, 1, 3);

    // 5: eight beats close the frame without in_last; beat 9 stalls
    for (int i = 0; i < 8; i++) send_beat(1, -1, 1'b0);
    @(negedge clk);
    check("t5_round_in_ready", int'(bus.in_ready), 0);
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.p_Re     = PW'(8);
    bus.p_Im     = PW'(8);
    @(negedge clk);
    check("t5_valid", int'(bus.out_valid), 1);
    check("t5_stall_in_ready", int'(bus.in_ready), 0);
    check("t5_count", int'(bus.out_count), 8);
    check("t5_re", $signed(bus.y_Re), 1);
    check("t5_im", $signed(bus.y_Im), -1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("t5_resume_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take_result("t5_beat9", 1, 1, 0, 1);

    // 6: backpressure keeps outputs stable, then reset discards a partial frame
    send_beat(16, 8, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t6_hold_valid", int'(bus.out_valid), 1);
      check("t6_hold_re", $signed(bus.y_Re), 2);
      check("t6_hold_im", $signed(bus.y_Im), 1);
      @(negedge clk);
    end
    take_result("t6", 2, 1, 0, 1);
    send_beat(16, 8, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_post_rst_in_ready", int'(bus.in_ready), 1);
    check("t6_post_rst_valid", int'(bus.out_valid), 0);
    check("t6_post_rst_re", $signed(bus.y_Re), 0);
    check("t6_post_rst_im", $signed(bus.y_Im), 0);
    check("t6_post_rst_sat", int'(bus.y_sat), 0);
    check("t6_post_rst_count", int'(bus.out_count), 0);
    send_beat(8, 8, 1'b1);
    take_result("t6_fresh", 1, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
